// File: rtl/eth_rx_parser.sv
// Ethernet/IPv4/UDP RX header parser: qualifies frames for LOCAL_MAC/UDP_PORT and emits one descriptor per frame.
// Descriptor valid one cycle after tlast; a qualifying frame ending while a descriptor is stalled is dropped and counted.
module eth_rx_parser #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
  parameter logic [15:0] UDP_PORT  = 16'd3000
) (
  input  logic        clk156,
  input  logic        eth_rst,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_desc_valid,
  input  logic        m_desc_ready,
  output logic [31:0] m_desc_src_ip,
  output logic [31:0] m_desc_dst_ip,
  output logic [15:0] m_desc_src_port,
  output logic [15:0] m_desc_udp_len,
  output logic [31:0] cnt_frames,
  output logic [31:0] cnt_bad,
  output logic [31:0] cnt_match,
  output logic [31:0] cnt_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_WAIT, S_SKIP} state_t;

  state_t      state;
  logic [2:0]  beat_idx;
  logic [31:0] cap_src_ip;
  logic [15:0] cap_dst_ip_hi, cap_dst_ip_lo, cap_src_port, cap_udp_len;

  logic [7:0]  b [8];
  logic [47:0] dst_mac;
  logic        mac_ok, beat_ok, on_beat4, qual, stalled;
  logic [15:0] dst_ip_lo_nxt, src_port_nxt, udp_len_nxt;

  always_comb begin
    for (int i = 0; i < 8; i++) b[i] = s_axis_tdata[8*i +: 8];
    dst_mac  = {b[0], b[1], b[2], b[3], b[4], b[5]};
    mac_ok   = (dst_mac == LOCAL_MAC) || (dst_mac == 48'hFFFF_FFFF_FFFF);
    on_beat4 = (state == S_HDR) && (beat_idx == 3'd4);
    case (beat_idx)
      3'd1:    beat_ok = ({b[4], b[5]} == 16'h0800) && (b[6] == 8'h45);
      3'd2:    beat_ok = (({b[4], b[5]} & 16'h3FFF) == 16'h0000) && (b[7] == 8'h11);
      3'd4:    beat_ok = ({b[4], b[5]} == UDP_PORT);
      default: beat_ok = 1'b1;
    endcase
    // A frame ending on beat4 still has its last header fields on the bus.
    dst_ip_lo_nxt = on_beat4 ? {b[0], b[1]} : cap_dst_ip_lo;
    src_port_nxt  = on_beat4 ? {b[2], b[3]} : cap_src_port;
    udp_len_nxt   = on_beat4 ? {b[6], b[7]} : cap_udp_len;
    qual = s_axis_tvalid && s_axis_tlast && s_axis_tuser &&
           ((state == S_WAIT) || (on_beat4 && beat_ok && (s_axis_tkeep == 8'hFF)));
    stalled = m_desc_valid && !m_desc_ready;
  end

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state           <= S_IDLE;
      beat_idx        <= 3'd0;
      cap_src_ip      <= '0;
      cap_dst_ip_hi   <= '0;
      cap_dst_ip_lo   <= '0;
      cap_src_port    <= '0;
      cap_udp_len     <= '0;
      m_desc_valid    <= 1'b0;
      m_desc_src_ip   <= '0;
      m_desc_dst_ip   <= '0;
      m_desc_src_port <= '0;
      m_desc_udp_len  <= '0;
      cnt_frames      <= '0;
      cnt_bad         <= '0;
      cnt_match       <= '0;
      cnt_ovf         <= '0;
    end else begin
      if (m_desc_valid && m_desc_ready) m_desc_valid <= 1'b0;
      if (s_axis_tvalid) begin
        case (state)
          S_IDLE: begin
            beat_idx <= 3'd1;
            state    <= mac_ok ? S_HDR : S_SKIP;
          end
          S_HDR: begin
            if (beat_idx == 3'd3) begin
              cap_src_ip    <= {b[2], b[3], b[4], b[5]};
              cap_dst_ip_hi <= {b[6], b[7]};
            end
            if (beat_idx == 3'd4) begin
              cap_dst_ip_lo <= dst_ip_lo_nxt;
              cap_src_port  <= src_port_nxt;
              cap_udp_len   <= udp_len_nxt;
            end
            if (!beat_ok)                state    <= S_SKIP;
            else if (beat_idx == 3'd4)   state    <= S_WAIT;
            else                         beat_idx <= beat_idx + 3'd1;
          end
          default: ;
        endcase
        // End of frame overrides whatever the header walk decided above.
        if (s_axis_tlast) begin
          state      <= S_IDLE;
          beat_idx   <= 3'd0;
          cnt_frames <= cnt_frames + 32'd1;
          if (!s_axis_tuser) cnt_bad <= cnt_bad + 32'd1;
        end
        if (qual) begin
          if (stalled) begin
            cnt_ovf <= cnt_ovf + 32'd1;
          end else begin
            m_desc_valid    <= 1'b1;
            m_desc_src_ip   <= cap_src_ip;
            m_desc_dst_ip   <= {cap_dst_ip_hi, dst_ip_lo_nxt};
            m_desc_src_port <= src_port_nxt;
            m_desc_udp_len  <= udp_len_nxt;
            cnt_match       <= cnt_match + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_parser.sv
// Bench for eth_rx_parser: directed scenarios plus random frames against a byte-level frame model.
module tb_eth_rx_parser;
  localparam logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

  logic        clk156 = 1'b0;
  logic        eth_rst;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        m_desc_valid, m_desc_ready;
  logic [31:0] m_desc_src_ip, m_desc_dst_ip;
  logic [15:0] m_desc_src_port, m_desc_udp_len;
  logic [31:0] cnt_frames, cnt_bad, cnt_match, cnt_ovf;

  eth_rx_parser dut (
    .clk156(clk156), .eth_rst(eth_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .m_desc_src_ip(m_desc_src_ip), .m_desc_dst_ip(m_desc_dst_ip),
    .m_desc_src_port(m_desc_src_port), .m_desc_udp_len(m_desc_udp_len),
    .cnt_frames(cnt_frames), .cnt_bad(cnt_bad), .cnt_match(cnt_match), .cnt_ovf(cnt_ovf)
  );

  always #5 clk156 = ~clk156;

  typedef struct packed {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sport;
    logic [15:0] ulen;
  } desc_t;

  typedef struct {
    logic [47:0] mac;
    logic [15:0] etype;
    logic [7:0]  vihl;
    logic [15:0] ff;
    logic [7:0]  proto;
    logic [31:0] sip, dip;
    logic [15:0] sport, dport, ulen;
    int          len;
  } frame_t;

  logic [7:0] frm [128];
  int         frm_len;
  int         passed = 0, total = 0;

  // Model state: pending descriptor and counters.
  bit         m_pend;
  desc_t      m_exp, cur_desc, got;
  int unsigned exp_frames, exp_bad, exp_match, exp_ovf;

  assign got = {m_desc_src_ip, m_desc_dst_ip, m_desc_src_port, m_desc_udp_len};

  function automatic frame_t good_frame();
    frame_t f;
    f.mac = LOCAL_MAC; f.etype = 16'h0800; f.vihl = 8'h45; f.ff = 16'h4000; f.proto = 8'h11;
    f.sip = 32'h0A000001; f.dip = 32'h0A000002; f.sport = 16'd1234; f.dport = 16'd3000;
    f.ulen = 16'd26; f.len = 64;
    return f;
  endfunction

  task automatic build_frame(input frame_t f);
    for (int i = 0; i < 128; i++) frm[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) frm[i] = f.mac[47-8*i -: 8];
    frm[12] = f.etype[15:8]; frm[13] = f.etype[7:0]; frm[14] = f.vihl;
    frm[20] = f.ff[15:8];    frm[21] = f.ff[7:0];    frm[23] = f.proto;
    for (int i = 0; i < 4; i++) begin
      frm[26+i] = f.sip[31-8*i -: 8];
      frm[30+i] = f.dip[31-8*i -: 8];
    end
    frm[34] = f.sport[15:8]; frm[35] = f.sport[7:0];
    frm[36] = f.dport[15:8]; frm[37] = f.dport[7:0];
    frm[38] = f.ulen[15:8];  frm[39] = f.ulen[7:0];
    frm_len = f.len;
  endtask

  // Whole-frame rule: full 40-byte header present, all header fields acceptable, frame good.
  function automatic bit model_qual(input bit tuser);
    logic [47:0] dmac;
    logic [15:0] et, ff, dp;
    dmac = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    et = {frm[12], frm[13]}; ff = {frm[20], frm[21]}; dp = {frm[36], frm[37]};
    return tuser && (frm_len >= 40) && (dmac == LOCAL_MAC || dmac == BCAST) &&
           et == 16'h0800 && frm[14] == 8'h45 && (ff & 16'h3FFF) == 16'h0 &&
           frm[23] == 8'h11 && dp == 16'd3000;
  endfunction

  task automatic model_clear();
    m_pend = 0; m_exp = '0;
    exp_frames = 0; exp_bad = 0; exp_match = 0; exp_ovf = 0;
  endtask

  // Advance one clock, updating the model from the inputs presented in this cycle.
  task automatic tick(input bit end_qual);
    bit hs, fend;
    hs   = m_pend && m_desc_ready;
    fend = s_axis_tvalid && s_axis_tlast;
    if (fend) begin
      exp_frames++;
      if (!s_axis_tuser) exp_bad++;
    end
    if (fend && end_qual) begin
      if (m_pend && !m_desc_ready) exp_ovf++;
      else begin m_pend = 1; m_exp = cur_desc; exp_match++; end
    end else if (hs) m_pend = 0;
    @(posedge clk156); #1;
  endtask

  task automatic send_frame(input bit tuser, input int gap);
    int nb, rem;
    bit q;
    q = model_qual(tuser);
    cur_desc.sip   = {frm[26], frm[27], frm[28], frm[29]};
    cur_desc.dip   = {frm[30], frm[31], frm[32], frm[33]};
    cur_desc.sport = {frm[34], frm[35]};
    cur_desc.ulen  = {frm[38], frm[39]};
    nb  = (frm_len + 7) / 8;
    rem = frm_len - 8 * (nb - 1);
    for (int bt = 0; bt < nb; bt++) begin
      for (int k = 0; k < 8; k++) s_axis_tdata[8*k +: 8] = frm[8*bt+k];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (bt == nb - 1);
      s_axis_tuser  = (bt == nb - 1) ? tuser : 1'($urandom);
      s_axis_tkeep  = (bt == nb - 1) ? (8'hFF >> (8 - rem)) : 8'hFF;
      tick(q);
      if (bt < nb - 1) begin
        for (int g = 0; g < gap; g++) begin
          s_axis_tvalid = 1'b0; s_axis_tlast = 1'($urandom); s_axis_tdata = {$urandom, $urandom};
          tick(1'b0);
        end
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic do_reset();
    eth_rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_desc_ready = 1'b0;
    @(posedge clk156); #1;
    eth_rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = 1'b0;
    do_reset();
    total++; if (m_desc_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_desc_valid); else passed++;
    total++; if (got !== '0) $display("FAIL reset_fields: got %h want 0", got); else passed++;
    total++; if (cnt_frames !== 0) $display("FAIL reset_frames: got %0d want 0", cnt_frames); else passed++;
    total++; if (cnt_bad !== 0) $display("FAIL reset_bad: got %0d want 0", cnt_bad); else passed++;
    total++; if (cnt_match !== 0) $display("FAIL reset_match: got %0d want 0", cnt_match); else passed++;
    total++; if (cnt_ovf !== 0) $display("FAIL reset_ovf: got %0d want 0", cnt_ovf); else passed++;
  endtask

  task automatic test_good_frame();
    do_reset();
    build_frame(good_frame());
    send_frame(1'b1, 0);
    total++; if (m_desc_valid !== 1'b1) $display("FAIL good_valid: got %b want 1", m_desc_valid); else passed++;
    total++; if (got !== {32'h0A000001, 32'h0A000002, 16'd1234, 16'd26})
      $display("FAIL good_fields: got %h want %h", got, {32'h0A000001, 32'h0A000002, 16'd1234, 16'd26}); else passed++;
    total++; if (cnt_frames !== 1) $display("FAIL good_frames: got %0d want 1", cnt_frames); else passed++;
    total++; if (cnt_match !== 1) $display("FAIL good_match: got %0d want 1", cnt_match); else passed++;
    m_desc_ready = 1'b1;
    tick(1'b0);
    total++; if (m_desc_valid !== 1'b0) $display("FAIL good_handshake: got %b want 0", m_desc_valid); else passed++;
    m_desc_ready = 1'b0;
  endtask

  task automatic test_filter();
    frame_t f;
    do_reset();
    f = good_frame(); f.dport = 16'd3001;
    build_frame(f); send_frame(1'b1, 0);
    total++; if (m_desc_valid !== 1'b0) $display("FAIL port_filter: got %b want 0", m_desc_valid); else passed++;
    f = good_frame(); f.etype = 16'h86DD;
    build_frame(f); send_frame(1'b1, 0);
    total++; if (m_desc_valid !== 1'b0) $display("FAIL etype_filter: got %b want 0", m_desc_valid); else passed++;
    total++; if (cnt_frames !== 2) $display("FAIL filter_frames: got %0d want 2", cnt_frames); else passed++;
    total++; if (cnt_match !== 0) $display("FAIL filter_match: got %0d want 0", cnt_match); else passed++;
  endtask

  task automatic test_bad_tuser();
    do_reset();
    build_frame(good_frame()); send_frame(1'b0, 0);
    total++; if (m_desc_valid !== 1'b0) $display("FAIL bad_valid: got %b want 0", m_desc_valid); else passed++;
    total++; if (cnt_bad !== 1) $display("FAIL bad_count: got %0d want 1", cnt_bad); else passed++;
  endtask

  task automatic test_back_to_back();
    frame_t f;
    do_reset();
    build_frame(good_frame()); send_frame(1'b1, 0);
    f = good_frame(); f.sip = 32'h0A000009; f.sport = 16'd999;
    build_frame(f); send_frame(1'b1, 0);
    total++; if (m_desc_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", m_desc_valid); else passed++;
    total++; if (got !== {32'h0A000001, 32'h0A000002, 16'd1234, 16'd26})
      $display("FAIL b2b_held: got %h want %h", got, {32'h0A000001, 32'h0A000002, 16'd1234, 16'd26}); else passed++;
    total++; if (cnt_ovf !== 1) $display("FAIL b2b_ovf: got %0d want 1", cnt_ovf); else passed++;
    total++; if (cnt_match !== 1) $display("FAIL b2b_match: got %0d want 1", cnt_match); else passed++;
    m_desc_ready = 1'b1;
    tick(1'b0);
    total++; if (m_desc_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", m_desc_valid); else passed++;
    m_desc_ready = 1'b0;
  endtask

  task automatic test_gaps();
    frame_t f;
    do_reset();
    f = good_frame(); f.mac = BCAST;
    build_frame(f); send_frame(1'b1, 3);
    total++; if (m_desc_valid !== 1'b1) $display("FAIL gap_valid: got %b want 1", m_desc_valid); else passed++;
    total++; if (got !== {32'h0A000001, 32'h0A000002, 16'd1234, 16'd26})
      $display("FAIL gap_fields: got %h want %h", got, {32'h0A000001, 32'h0A000002, 16'd1234, 16'd26}); else passed++;
  endtask

  task automatic test_beat4_boundary();
    frame_t f;
    do_reset();
    m_desc_ready = 1'b1;
    f = good_frame(); f.len = 40;
    build_frame(f); send_frame(1'b1, 0);
    total++; if (m_desc_valid !== 1'b1) $display("FAIL len40_valid: got %b want 1", m_desc_valid); else passed++;
    f.len = 39; f.sip = 32'hC0A80001;
    build_frame(f); send_frame(1'b1, 0);
    total++; if (m_desc_valid !== 1'b0) $display("FAIL len39_valid: got %b want 0", m_desc_valid); else passed++;
    total++; if (cnt_match !== 1) $display("FAIL boundary_match: got %0d want 1", cnt_match); else passed++;
    m_desc_ready = 1'b0;
  endtask

  task automatic test_runt_and_reset();
    frame_t f;
    do_reset();
    f = good_frame(); f.len = 24;
    build_frame(f); send_frame(1'b1, 0);
    total++; if (m_desc_valid !== 1'b0) $display("FAIL runt_valid: got %b want 0", m_desc_valid); else passed++;
    total++; if (cnt_frames !== 1) $display("FAIL runt_frames: got %0d want 1", cnt_frames); else passed++;
    f = good_frame(); f.sport = 16'd4321; f.ulen = 16'd100;
    build_frame(f); send_frame(1'b1, 0);
    total++; if (got !== {32'h0A000001, 32'h0A000002, 16'd4321, 16'd100} || m_desc_valid !== 1'b1)
      $display("FAIL after_runt: got %b/%h want 1/%h", m_desc_valid, got, {32'h0A000001, 32'h0A000002, 16'd4321, 16'd100});
    else passed++;
    eth_rst = 1'b1;
    @(posedge clk156); #1;
    total++; if (m_desc_valid !== 1'b0) $display("FAIL rst_pending_valid: got %b want 0", m_desc_valid); else passed++;
    total++; if ({cnt_frames, cnt_bad, cnt_match, cnt_ovf} !== 128'h0)
      $display("FAIL rst_pending_cnt: got %h want 0", {cnt_frames, cnt_bad, cnt_match, cnt_ovf}); else passed++;
    eth_rst = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    frame_t f;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    f.mac = LOCAL_MAC;
        2:       f.mac = BCAST;
        default: f.mac = {16'($urandom), 32'($urandom)};
      endcase
      f.etype = ($urandom_range(0, 5) == 0) ? 16'h86DD : 16'h0800;
      f.vihl  = ($urandom_range(0, 5) == 0) ? 8'h46 : 8'h45;
      case ($urandom_range(0, 5))
        0:       f.ff = 16'h2000;
        1:       f.ff = 16'h0001;
        2:       f.ff = 16'h8000;
        3:       f.ff = 16'h0000;
        default: f.ff = 16'h4000;
      endcase
      f.proto = ($urandom_range(0, 5) == 0) ? 8'h06 : 8'h11;
      f.dport = ($urandom_range(0, 4) == 0) ? 16'd3001 : 16'd3000;
      f.sip = $urandom; f.dip = $urandom; f.sport = 16'($urandom); f.ulen = 16'($urandom);
      f.len = $urandom_range(20, 80);
      m_desc_ready = ($urandom_range(0, 3) != 0);
      build_frame(f);
      send_frame($urandom_range(0, 3) != 0, $urandom_range(0, 2));
      total++; if (m_desc_valid !== m_pend) $display("FAIL rnd_valid[%0d]: got %b want %b", n, m_desc_valid, m_pend); else passed++;
      if (m_pend) begin
        total++; if (got !== m_exp) $display("FAIL rnd_fields[%0d]: got %h want %h", n, got, m_exp); else passed++;
      end
      total++; if ({cnt_frames, cnt_bad, cnt_match, cnt_ovf} !== {exp_frames, exp_bad, exp_match, exp_ovf})
        $display("FAIL rnd_counters[%0d]: got %h want %h", n, {cnt_frames, cnt_bad, cnt_match, cnt_ovf},
                 {exp_frames, exp_bad, exp_match, exp_ovf});
      else passed++;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick(1'b0);
    end
  endtask

  initial begin
    eth_rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; m_desc_ready = 1'b0;
    repeat (2) @(posedge clk156);
    #1;
    test_reset();
    test_good_frame();
    test_filter();
    test_bad_tuser();
    test_back_to_back();
    test_gaps();
    test_beat4_boundary();
    test_runt_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/eth_rx_parser.md
Name: eth_rx_parser

Overview:
- Receive-side stage sitting directly downstream of the 10G Ethernet MAC RX AXI-Stream output (64-bit, no back-pressure toward the MAC).
- Parses the Ethernet/IPv4/UDP header of each frame on the fly.
- For good frames addressed to this node and a configured UDP port, emits one header descriptor with a valid/ready handshake to the application logic.
- Keeps frame statistics counters.

Parameters:
- LOCAL_MAC, 48'h00_11_22_33_44_55, station MAC. A frame is accepted if its dst MAC equals this value or ff:ff:ff:ff:ff:ff.
- UDP_PORT, 16'd3000, UDP destination port that qualifies a frame.

Ports:
- clk156  in  1  156.25 MHz Ethernet core clock; all logic synchronous to its rising edge.
- eth_rst  in  1  Synchronous, active-high reset.
- s_axis_tvalid  in  1  MAC RX beat valid. No tready: every valid beat is consumed.
- s_axis_tdata  in  64  Beat data; byte n of the beat is tdata[8n+7:8n], lower byte address = earlier on wire.
- s_axis_tkeep  in  8  Byte enables; contiguous from bit 0, meaningful only on the tlast beat.
- s_axis_tlast  in  1  Last beat of frame.
- s_axis_tuser  in  1  Sampled on the tlast beat: 1 = good frame (FCS/length OK), 0 = bad.
- m_desc_valid  out  1  Descriptor valid.
- m_desc_ready  in  1  Descriptor accepted when valid && ready.
- m_desc_src_ip  out  32  IPv4 source address.
- m_desc_dst_ip  out  32  IPv4 destination address.
- m_desc_src_port  out  16  UDP source port.
- m_desc_udp_len  out  16  UDP length field.
- cnt_frames  out  32  Frames seen (tlast beats).
- cnt_bad  out  32  Frames with tuser=0 on tlast.
- cnt_match  out  32  Descriptors emitted.
- cnt_ovf  out  32  Qualifying frames lost because a descriptor was still pending.

Behaviour:
- Reset: all outputs 0; FSM in S_IDLE; beat index 0; header capture registers 0.
- Multi-byte fields are network order: the byte at the lower address is the MSB.
- Beat map (byte offsets):
  - beat0: dst MAC 0-5.
  - beat1: ethertype 12-13, ver/IHL 14.
  - beat2: flags/frag 20-21, proto 23.
  - beat3: src IP 26-29, dst IP bytes 30-31.
  - beat4: dst IP bytes 32-33, src port 34-35, dst port 36-37, UDP len 38-39.
- Only cycles with s_axis_tvalid=1 advance state. Gaps (tvalid=0) hold all state.
- FSM:
  - S_IDLE: a valid beat is beat0. Capture and check dst MAC. Go to S_HDR with index 1, or S_SKIP on mismatch.
  - S_HDR: beats 1-4, checking per beat.
    - beat1: ethertype==16'h0800 and byte14==8'h45.
    - beat2: (flags/frag & 16'h3FFF)==0 and proto==8'h11.
    - beat4: dst port==UDP_PORT.
    - Any failed check -> S_SKIP.
    - After beat4 passes -> S_WAIT.
  - S_WAIT: consume payload beats until tlast.
  - S_SKIP: consume beats until tlast; the frame cannot qualify.
- Frame end:
  - A tlast beat in any state ends the frame and returns the FSM to S_IDLE; the next valid beat is beat0.
  - tlast on beats 0-3 makes the frame short, so it does not qualify.
  - tlast on beat4 qualifies only if s_axis_tkeep==8'hFF.
- Qualify = header checks passed and tuser=1 on the tlast beat.
- Descriptor:
  - The fields are driven from the capture registers. They load into the output registers, and m_desc_valid rises, on the cycle after the tlast beat (latency 1).
  - m_desc_valid stays high and the fields stay stable until valid && ready.
  - If a qualifying frame ends while m_desc_valid=1 and m_desc_ready=0 that cycle, the new descriptor is dropped, cnt_ovf increments, and the held descriptor is unchanged.
  - If ready=1 in the same cycle as the load, the old descriptor completes and the new one loads (no drop).
- Counters:
  - cnt_frames increments on every tlast beat; cnt_bad increments when tuser=0 on that beat.
  - cnt_match increments on each descriptor load. cnt_ovf increments as described above.
  - All counters are 32-bit and wrap modulo 2^32.
- Reset mid-frame: the FSM returns to S_IDLE and any pending descriptor is discarded. The MAC shares eth_rst, so no partial frame follows reset.

Test Plan:
- Good UDP frame: dst MAC=LOCAL_MAC, src IP 10.0.0.1, dst IP 10.0.0.2, src port 1234, dst port 3000, UDP len 16'd26, 8 beats, tuser=1 -> m_desc_valid=1 one cycle after tlast with 32'h0A000001 / 32'h0A000002 / 16'd1234 / 16'd26; cnt_frames=1, cnt_match=1.
- Same frame but dst port 3001, then a frame with ethertype 16'h86DD -> no descriptor; cnt_frames=2, cnt_match=0.
- Good header, tuser=0 on tlast -> no descriptor; cnt_bad=1.
- Two qualifying frames back-to-back with m_desc_ready=0 -> first descriptor held unchanged, cnt_ovf=1. Raise ready -> one handshake, then m_desc_valid=0.
- Frame with tvalid gaps of 3 cycles between every beat, and a broadcast dst MAC -> descriptor identical to the gap-free case.
- 3-beat runt with tlast, followed by a good frame -> runt ignored (cnt_frames=1, no descriptor), good frame parsed correctly from its beat0; eth_rst asserted while a descriptor is pending -> m_desc_valid=0 and all counters 0 the next cycle.
